// File: rtl/sram_arbiter.sv
// Two-port arbiter sequencing single accesses onto a shared frame-buffer SRAM.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 1 has fixed priority.
module sram_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 1536,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    input  logic              req2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata2,
    output logic              gnt2,
    output logic              done2,
    output logic [DATA_W-1:0] rdata,
    output logic              sram_read_enable,
    output logic              sram_write_enable,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] sram_read_data
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner2_q, owner2_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                gnt1_q, gnt1_d;
    logic                gnt2_q, gnt2_d;
    logic                done1_q, done1_d;
    logic                done2_q, done2_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic                pick2;
    logic                sel_we;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // prio2_q set means port 1 was served last, so port 2 wins the next tie
    logic prio2_q, prio2_d;

    assign pick2 = req2 && (!req1 || prio2_q);

    always_comb begin
        prio2_d = prio2_q;
        if (state_q == ISSUE) begin
            prio2_d = !owner2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio2_q <= 1'b0;
        end else begin
            prio2_q <= prio2_d;
        end
    end
`else
    assign pick2 = req2 && !req1;
`endif

    assign sel_we = pick2 ? we2 : we1;

    always_comb begin
        state_d  = state_q;
        owner2_d = owner2_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        gnt1_d   = 1'b0;
        gnt2_d   = 1'b0;
        done1_d  = 1'b0;
        done2_d  = 1'b0;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req1 || req2) begin
                    owner2_d = pick2;
                    we_d     = sel_we;
                    addr_d   = pick2 ? addr2 : addr1;
                    wdata_d  = pick2 ? wdata2 : wdata1;
                    gnt1_d   = !pick2;
                    gnt2_d   = pick2;
                    rd_en_d  = !sel_we;
                    wr_en_d  = sel_we;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    done1_d = !owner2_q;
                    done2_d = owner2_q;
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Counter value 1 marks the cycle in which read data is valid
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = sram_read_data;
                    done1_d = !owner2_q;
                    done2_d = owner2_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner2_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            gnt1_q   <= 1'b0;
            gnt2_q   <= 1'b0;
            done1_q  <= 1'b0;
            done2_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner2_q <= owner2_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            gnt1_q   <= gnt1_d;
            gnt2_q   <= gnt2_d;
            done1_q  <= done1_d;
            done2_q  <= done2_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
        end
    end

    assign gnt1              = gnt1_q;
    assign gnt2              = gnt2_q;
    assign done1             = done1_q;
    assign done2             = done2_q;
    assign rdata             = rdata_q;
    assign sram_read_enable  = rd_en_q;
    assign sram_write_enable = wr_en_q;
    assign sram_address      = addr_q;
    assign sram_write_data   = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a two-cycle-latency SRAM model (16 words, low address bits).
module tb_sram_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 1536;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req1, we1, req2, we2;
    logic [ADDR_W-1:0] addr1, addr2;
    logic [DATA_W-1:0] wdata1, wdata2;
    logic              gnt1, gnt2, done1, done2;
    logic [DATA_W-1:0] rdata;
    logic              sram_read_enable, sram_write_enable;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;

    int errors = 0;
    int checks = 0;
    int en_cycles = 0;
    int done_cnt = 0;
    logic both_high = 1'b0;

    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] rd_stage;
    logic [DATA_W-1:0] pat_a5, pat_d, val_1234, pat_w;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
        .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2), .gnt2(gnt2), .done2(done2),
        .rdata(rdata),
        .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    always #5 clk = ~clk;

    // SRAM model: data appears two cycles after the read-enable cycle, zero otherwise
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[15] <= {{(DATA_W-16){1'b0}}, 16'h1234};
            rd_stage <= '0;
            sram_read_data <= '0;
        end else begin
            if (sram_write_enable) mem[sram_address[3:0]] <= sram_write_data;
            rd_stage <= sram_read_enable ? mem[sram_address[3:0]] : '0;
            sram_read_data <= rd_stage;
        end
    end

    always @(negedge clk) begin
        if (sram_read_enable === 1'b1 || sram_write_enable === 1'b1) en_cycles++;
        if (sram_read_enable === 1'b1 && sram_write_enable === 1'b1) both_high = 1'b1;
        if (done1 === 1'b1 || done2 === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed(low64)=%0h expected(low64)=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int d0;
        logic e2;
        pat_a5   = {(DATA_W/8){8'hA5}};
        pat_d    = {(DATA_W/32){32'hDEADBEEF}};
        pat_w    = {(DATA_W/32){32'h0BADF00D}};
        val_1234 = '0;
        val_1234[15:0] = 16'h1234;

        rst = 1'b1; req1 = 1'b0; req2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
        addr1 = '0; addr2 = '0; wdata1 = '0; wdata2 = '0;
        repeat (3) tick();
        chkb("rst_gnt1", gnt1, 1'b0);
        chkb("rst_gnt2", gnt2, 1'b0);
        chkb("rst_done", done1 | done2, 1'b0);
        chkb("rst_en", sram_read_enable | sram_write_enable, 1'b0);
        chka("rst_addr", sram_address, '0);
        chkd("rst_rdata", rdata, '0);
        rst = 1'b0;
        $display("step reset done");

        // Port 1 write
        req1 = 1'b1; we1 = 1'b1; addr1 = 19'h00010; wdata1 = pat_a5;
        tick();
        chkb("w1_gnt1", gnt1, 1'b1);
        chkb("w1_wen", sram_write_enable, 1'b1);
        chkb("w1_ren", sram_read_enable, 1'b0);
        chka("w1_addr", sram_address, 19'h00010);
        chkd("w1_data", sram_write_data, pat_a5);
        req1 = 1'b0;
        tick();
        chkb("w1_done1", done1, 1'b1);
        chkb("w1_wen_off", sram_write_enable, 1'b0);
        tick();
        chkb("w1_done1_off", done1, 1'b0);
        $display("txn port1 write addr=00010");

        // Port 2 read, data valid in cycle 4
        req2 = 1'b1; we2 = 1'b0; addr2 = 19'h7FFFF;
        tick();
        chkb("r2_gnt2", gnt2, 1'b1);
        chkb("r2_ren", sram_read_enable, 1'b1);
        chkb("r2_wen", sram_write_enable, 1'b0);
        req2 = 1'b0;
        tick();
        chkb("r2_c2_done", done2, 1'b0);
        tick();
        chkb("r2_c3_done", done2, 1'b0);
        tick();
        chkb("r2_done2", done2, 1'b1);
        chkd("r2_rdata", rdata, val_1234);
        tick();
        chkb("r2_done2_off", done2, 1'b0);
        $display("txn port2 read addr=7ffff rdata=%0h", rdata[63:0]);

        // Both requesting, six writes
        req1 = 1'b1; req2 = 1'b1; we1 = 1'b1; we2 = 1'b1;
        addr1 = 19'h1; addr2 = 19'h2; wdata1 = pat_w; wdata2 = pat_w;
        for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            e2 = (i % 2) == 1;
`else
            e2 = 1'b0;
`endif
            tick();
            chkb("tie_gnt1", gnt1, !e2);
            chkb("tie_gnt2", gnt2, e2);
            $display("txn tie %0d gnt1=%b gnt2=%b", i, gnt1, gnt2);
            tick();
            tick();
        end
        req1 = 1'b0; req2 = 1'b0;

        // Write port 1, read same address from port 2
        req1 = 1'b1; we1 = 1'b1; addr1 = 19'h3; wdata1 = pat_d;
        tick();
        req1 = 1'b0;
        tick();
        chkb("wr_done1", done1, 1'b1);
        chkd("wr_rdata_hold", rdata, val_1234);
        tick();
        req2 = 1'b1; we2 = 1'b0; addr2 = 19'h3;
        tick();
        chkb("rd_gnt2", gnt2, 1'b1);
        req2 = 1'b0;
        repeat (RD_LAT + 1) tick();
        chkb("rd_done2", done2, 1'b1);
        chkd("rd_back", rdata, pat_d);
        tick();
        $display("txn write/read addr=3 rdata=%0h", rdata[63:0]);

        // Reset during WAIT of a read
        req1 = 1'b1; we1 = 1'b0; addr1 = 19'h5;
        tick();
        req1 = 1'b0;
        tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chkb("ar_en", sram_read_enable | sram_write_enable, 1'b0);
        chkb("ar_gnt", gnt1 | gnt2, 1'b0);
        chka("ar_addr", sram_address, '0);
        chkd("ar_rdata", rdata, '0);
        tick();
        tick();
        chki("ar_no_done", done_cnt, d0);
        req2 = 1'b1; we2 = 1'b1; addr2 = 19'h6; wdata2 = pat_w;
        tick();
        chkb("ar_gnt2", gnt2, 1'b1);
        req2 = 1'b0;
        tick();
        chkb("ar_done2", done2, 1'b1);
        tick();
        $display("txn reset-abort then port2 write addr=6");

        // Port 2 request raised during port 1 ISSUE
        req1 = 1'b1; we1 = 1'b1; addr1 = 19'h7; wdata1 = pat_a5;
        tick();
        chkb("ov_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        req2 = 1'b1; we2 = 1'b1; addr2 = 19'h8; wdata2 = pat_d;
        tick();
        chkb("ov_done1", done1, 1'b1);
        chkb("ov_gnt2_early", gnt2, 1'b0);
        tick();
        chkb("ov_idle_gnt2", gnt2, 1'b0);
        chkb("ov_idle_wen", sram_write_enable, 1'b0);
        tick();
        chkb("ov_gnt2", gnt2, 1'b1);
        chka("ov_addr2", sram_address, 19'h8);
        req2 = 1'b0;
        tick();
        chkb("ov_done2", done2, 1'b1);
        tick();
        $display("txn port1 then port2 writes addr=7,8");

        chkb("no_overlap", both_high, 1'b0);
        chki("enable_cycles", en_cycles, 14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencing arbiter that shares the single frame-buffer SRAM port between two requesters, for example the rasterizer writer and the display/readback path. Each requester raises a request, and the block grants one of them. It then drives one registered SRAM access, waits out the SRAM read latency, returns read data, and signals completion. Every SRAM access passes through this block, so the SRAM never sees two conflicting sets of enables.

## Interface
Parameters:
- ADDR_W, 19, SRAM address width
- DATA_W, 1536, SRAM word width
- RD_LAT, 2, cycles from the read-enable cycle to valid `sram_read_data`; legal range 1..15

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req1  in  1  port 1 request (level)
- we1  in  1  port 1 access type: 1 = write, 0 = read
- addr1  in  ADDR_W  port 1 address
- wdata1  in  DATA_W  port 1 write data
- gnt1  out  1  one-cycle pulse: port 1 request accepted, inputs captured
- done1  out  1  one-cycle pulse: port 1 access complete
- req2, we2, addr2, wdata2, gnt2, done2: same as port 1, for port 2
- rdata  out  DATA_W  registered read data; valid while a `doneN` pulse is high for a read
- sram_read_enable  out  1  SRAM read strobe
- sram_write_enable  out  1  SRAM write strobe
- sram_address  out  ADDR_W  SRAM address
- sram_write_data  out  DATA_W  SRAM write data
- sram_read_data  in  DATA_W  SRAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - Any `reqN` high: choose a winner, latch its `we`, `addr` and `wdata` into internal registers, record the owner, and move to ISSUE.
- **ISSUE** (exactly one cycle)
  - Pulse the owner's `gntN`.
  - Drive `sram_read_enable = !we_latched` and `sram_write_enable = we_latched`.
  - Next state: write → DONE; read → WAIT, loading the latency counter with RD_LAT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `sram_read_data` into `rdata` and move to DONE.
- **DONE** (exactly one cycle)
  - Pulse the owner's `doneN`, then return to IDLE.
- Outputs outside ISSUE:
  - Both SRAM enables are 0.
  - `sram_address` and `sram_write_data` always show the latched registers.
  - `rdata` holds until the next read capture; writes do not change it.
- Requester rules:
  - Inputs are sampled only in IDLE.
  - After `gntN`, the requester may change its inputs freely.
  - A `reqN` still high in the IDLE cycle after DONE is treated as a new request.
- Tie-break when both requests are high in IDLE: see Configuration. A lone request always wins.

## Timing
- Reset values: state IDLE, every output 0, `rdata` 0, latched registers 0, round-robin pointer favouring port 1.
- Reset asserted in any state aborts the access:
  - No `done` pulse is generated.
  - Enables fall to 0 on the next edge.
- Write, with request sampled at edge E:
  - ISSUE in cycle E+1.
  - `doneN` in cycle E+2.
- Read, with request sampled at edge E:
  - ISSUE in cycle E+1.
  - WAIT for RD_LAT cycles.
  - `doneN` with valid `rdata` in cycle E+2+RD_LAT.
- Transaction spacing: at least one IDLE cycle between transactions. Back-to-back writes therefore complete at most once every 3 cycles.
- Enables are never both high, and never high outside ISSUE.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` defined:
  - A one-bit last-served pointer updates in each ISSUE cycle.
  - On a tie, the port not served last wins.
  - The first tie after reset goes to port 1.
- Not defined:
  - Fixed priority: port 1 always wins ties.
  - No pointer register is built.
  - Port 2 can starve while port 1 holds its request.

## Test plan
- Reset, then single write from port 1 (addr 0x00010, data all-0xA5):
  - `gnt1` in cycle 1.
  - `sram_write_enable` high exactly in cycle 1 with the matching address and data.
  - `done1` in cycle 2.
  - `sram_read_enable` stays 0 throughout.
- Port 2 read at addr 0x7FFFF with RD_LAT=2, SRAM model returning 0x1234 (zero-extended) 2 cycles after the read enable:
  - `done2` in cycle 4.
  - `rdata` = 0x1234.
- `req1` and `req2` held high for 6 transactions (all writes):
  - With the macro defined: grants alternate 1,2,1,2,1,2.
  - Without it: all 6 grants go to port 1.
- Write then read of the same address from opposite ports:
  - The read returns the written data.
  - `rdata` is unchanged by the intervening write.
- `rst` asserted during WAIT of a read:
  - No `done` pulse.
  - All outputs 0 on the next cycle.
  - A subsequent request completes normally.
- Request from port 2 arriving during port 1's ISSUE:
  - Port 2 is served only after port 1's DONE plus one IDLE cycle.
  - No overlap of enables at any point.
